// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter, fetch buffer and instruction register for the multicycle datapath
module pc_ir_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_escir,
    input  logic              i_esccp,
    input  logic              i_esccondcp,
    input  logic [1:0]        i_fontecp,
    input  logic [ADDR_W-1:0] i_alu_res,
    input  logic              i_zero,
    input  logic              i_imem_ack,
    input  logic [15:0]       i_imem_data,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [3:0]        o_codop,
    output logic [3:0]        o_rd,
    output logic [3:0]        o_rs,
    output logic [3:0]        o_rt,
    output logic              o_ir_valid,
    output logic [15:0]       o_retired
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [15:0]       r_fbuf;
    logic [15:0]       r_retired;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_pc_wr;

    // Next-PC selection: ESCCP follows FONTECP, a lone ESCCONDCP branches on ZERO
    always_comb begin
        w_seq     = r_pc + ADDR_W'(1);
        w_off     = ADDR_W'($signed(r_ir[3:0]));
        w_br      = w_seq + w_off;
        w_pc_wr   = (r_state == S_EXEC) && (i_esccp || i_esccondcp);
        w_next_pc = !i_esccp         ? (i_zero ? w_br : w_seq) :
                    i_fontecp == 2'b00 ? i_alu_res :
                    i_fontecp == 2'b01 ? w_br :
                    i_fontecp == 2'b10 ? r_ir[ADDR_W-1:0] : r_pc;
    end

    // Fetch / ready / execute sequencing; strobes outside their state are ignored
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_fbuf    <= '0;
            r_retired <= '0;
        end else if (r_state == S_FETCH && i_imem_ack) begin
            r_fbuf  <= i_imem_data;
            r_state <= S_READY;
        end else if (r_state == S_READY && i_escir) begin
            r_ir    <= r_fbuf;
            r_state <= S_EXEC;
        end else if (w_pc_wr) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 16'd1;
            r_state   <= S_FETCH;
        end else if (r_state == 2'd3) begin
            r_state <= S_FETCH;
        end
    end

    assign o_imem_req  = (r_state == S_FETCH) && !i_rst;
    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_codop     = r_ir[15:12];
    assign o_rd        = r_ir[11:8];
    assign o_rs        = r_ir[7:4];
    assign o_rt        = r_ir[3:0];
    assign o_ir_valid  = (r_state == S_READY);
    assign o_retired   = r_retired;
endmodule

// File: tb/tb_pc_ir_unit.sv
// tb_pc_ir_unit: directed vectors for pc_ir_unit with hand-computed expectations
module tb_pc_ir_unit;
    logic        clk = 1'b0;
    logic        rst, escir, esccp, esccondcp, zero, ack;
    logic [1:0]  fontecp;
    logic [7:0]  alu_res;
    logic [15:0] imem_data;
    logic        imem_req, ir_valid;
    logic [7:0]  imem_addr, pc;
    logic [3:0]  codop, rd, rs, rt;
    logic [15:0] retired;
    int          checks = 0;
    int          errors = 0;

    pc_ir_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .i_clk(clk), .i_rst(rst), .i_escir(escir), .i_esccp(esccp),
        .i_esccondcp(esccondcp), .i_fontecp(fontecp), .i_alu_res(alu_res),
        .i_zero(zero), .i_imem_ack(ack), .i_imem_data(imem_data),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .o_pc(pc),
        .o_codop(codop), .o_rd(rd), .o_rs(rs), .o_rt(rt),
        .o_ir_valid(ir_valid), .o_retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait for a request, then acknowledge after lat cycles with data
    task automatic fetch(input logic [15:0] data, input int lat);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {15'd0, imem_req}, 16'd1);
        repeat (lat - 1) @(negedge clk);
        ack       = 1'b1;
        imem_data = data;
        @(negedge clk);
        ack       = 1'b0;
        imem_data = 16'h0;
    endtask

    task automatic pulse(input logic ir, input logic cp, input logic cc,
                         input logic [1:0] f, input logic [7:0] alu, input logic z);
        escir = ir; esccp = cp; esccondcp = cc; fontecp = f; alu_res = alu; zero = z;
        @(negedge clk);
        escir = 0; esccp = 0; esccondcp = 0; fontecp = 0; alu_res = 0; zero = 0;
    endtask

    // Fetch, load IR, then write PC with the given strobes
    task automatic instr(input logic [15:0] data, input logic cp, input logic cc,
                         input logic [1:0] f, input logic z);
        fetch(data, 1);
        pulse(1, 0, 0, 0, 0, 0);
        pulse(0, cp, cc, f, 8'h00, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1; escir = 0; esccp = 0; esccondcp = 0; zero = 0; ack = 0;
        fontecp = 0; alu_res = 0; imem_data = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_pc", {8'd0, pc}, 16'h0000);
        chk("rst_codop", {12'd0, codop}, 16'h0);
        chk("rst_valid", {15'd0, ir_valid}, 16'd0);
        chk("rst_retired", retired, 16'd0);
        rst = 0;
        @(negedge clk);
        chk("first_req", {15'd0, imem_req}, 16'd1);
        chk("first_addr", {8'd0, imem_addr}, 16'h0000);

        fetch(16'h1234, 2);
        chk("ack_valid", {15'd0, ir_valid}, 16'd1);
        pulse(1, 0, 0, 0, 0, 0);
        chk("fields", {codop, rd, rs, rt}, 16'h1234);
        chk("escir_valid", {15'd0, ir_valid}, 16'd0);
        chk("exec_req", {15'd0, imem_req}, 16'd0);
        pulse(0, 1, 0, 2'b00, 8'h01, 0);
        chk("seq_pc", {8'd0, pc}, 16'h0001);
        chk("seq_addr", {8'd0, imem_addr}, 16'h0001);
        chk("seq_retired", retired, 16'd1);
        chk("seq_req", {15'd0, imem_req}, 16'd1);

        pulse(1, 1, 0, 2'b10, 8'h55, 0);
        chk("ign_pc", {8'd0, pc}, 16'h0001);
        chk("ign_codop", {12'd0, codop}, 16'h1);
        chk("ign_req", {15'd0, imem_req}, 16'd1);
        chk("ign_retired", retired, 16'd1);

        instr(16'hB0F3, 1, 0, 2'b10, 0);
        chk("jump_pc", {8'd0, pc}, 16'h00F3);
        chk("jump_retired", retired, 16'd2);

        instr(16'hB010, 1, 0, 2'b10, 0);
        instr(16'hC00E, 0, 1, 2'b10, 1);
        chk("br_taken", {8'd0, pc}, 16'h000F);
        instr(16'hB010, 1, 0, 2'b10, 0);
        instr(16'hC00E, 0, 1, 2'b00, 0);
        chk("br_not_taken", {8'd0, pc}, 16'h0011);
        instr(16'hA00E, 1, 0, 2'b01, 0);
        chk("rel_pc", {8'd0, pc}, 16'h0010);
        instr(16'h0000, 1, 0, 2'b11, 0);
        chk("hold_pc", {8'd0, pc}, 16'h0010);
        chk("hold_retired", retired, 16'd8);

        instr(16'hB0FF, 1, 0, 2'b10, 0);
        instr(16'hC007, 0, 1, 2'b00, 1);
        chk("wrap_pc", {8'd0, pc}, 16'h0007);
        instr(16'hC008, 0, 1, 2'b00, 1);
        chk("neg8_pc", {8'd0, pc}, 16'h0000);

        instr(16'hB0F3, 1, 1, 2'b10, 1);
        chk("both_pc", {8'd0, pc}, 16'h00F3);
        chk("both_retired", retired, 16'd12);

        fetch(16'hB020, 1);
        ack = 1; imem_data = 16'hFFFF;
        @(negedge clk);
        ack = 0; imem_data = 0;
        chk("late_ack_valid", {15'd0, ir_valid}, 16'd1);
        pulse(1, 0, 0, 0, 0, 0);
        chk("late_ack_codop", {12'd0, codop}, 16'h000B);
        pulse(1, 0, 0, 0, 0, 0);
        chk("exec_escir_valid", {15'd0, ir_valid}, 16'd0);
        chk("exec_escir_req", {15'd0, imem_req}, 16'd0);
        pulse(0, 1, 0, 2'b10, 0, 0);
        chk("pre_rst_pc", {8'd0, pc}, 16'h0020);
        chk("pre_rst_req", {15'd0, imem_req}, 16'd1);

        rst = 1; ack = 1; imem_data = 16'hFFFF;
        #1;
        chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
        @(negedge clk);
        chk("mid_rst_pc", {8'd0, pc}, 16'h0000);
        chk("mid_rst_valid", {15'd0, ir_valid}, 16'd0);
        chk("mid_rst_codop", {12'd0, codop}, 16'h0);
        chk("mid_rst_retired", retired, 16'd0);
        rst = 0; ack = 0; imem_data = 0;
        @(negedge clk);
        chk("post_rst_req", {15'd0, imem_req}, 16'd1);
        chk("post_rst_addr", {8'd0, imem_addr}, 16'h0000);
        fetch(16'h5678, 3);
        pulse(1, 0, 0, 0, 0, 0);
        chk("post_rst_fields", {codop, rd, rs, rt}, 16'h5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
